// File: rtl/prf_write_arbiter.sv
// prf_write_arbiter
//   Write side of the physical register file. Each of PRF_WR_COUNT producers
//   owns a 1-entry holding buffer. Every cycle, each PRF bank (selected by the
//   low LOG_PRF_BANK_COUNT bits of the PR) grants at most one buffered write.
//   The bank outputs are registered and also feed IQ wakeup / ROB complete.
//
//   Optional build macro: PRF_WR_FIXED_PRIO_EN
//     defined   -> per-bank fixed priority, lowest requestor index wins
//     undefined -> per-bank round-robin starting at rr_ptr[b]
//
// Ports
//   i_clk                    clock
//   i_rst                    synchronous reset, active high
//   i_WR_valid_by_wr         requestor presents a write
//   i_WR_PR_by_wr            destination physical register per requestor
//   i_WR_data_by_wr          write data per requestor
//   o_WR_ready_by_wr         holding buffer can accept this cycle
//   o_bank_WR_valid_by_bank  bank write enable (registered)
//   o_bank_WR_PR_by_bank     full PR written on that bank (registered)
//   o_bank_WR_data_by_bank   data written on that bank (registered)
module prf_write_arbiter #(
    parameter int PRF_WR_COUNT       = 7,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int PR_COUNT           = 128,
    parameter int LOG_PR_COUNT       = $clog2(PR_COUNT),
    parameter int XLEN               = 32
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [PRF_WR_COUNT-1:0]                      i_WR_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]    i_WR_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]            i_WR_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                      o_WR_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                    o_bank_WR_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  o_bank_WR_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]          o_bank_WR_data_by_bank
);

    localparam int IDX_W = (PRF_WR_COUNT > 1) ? $clog2(PRF_WR_COUNT) : 1;

    // Holding buffers
    logic [PRF_WR_COUNT-1:0]                     r_buf_valid;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]   r_buf_pr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]           r_buf_data;

    // Registered bank ports
    logic [PRF_BANK_COUNT-1:0]                   r_bank_valid;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] r_bank_pr;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         r_bank_data;

    // Arbitration results
    logic [PRF_WR_COUNT-1:0]                     w_grant;
    logic [PRF_BANK_COUNT-1:0]                   w_win_vld;
    logic [PRF_BANK_COUNT-1:0][IDX_W-1:0]        w_win_idx;
    logic [PRF_WR_COUNT-1:0]                     w_ready;

    // (base + k) mod PRF_WR_COUNT; count need not be a power of two, so wrap explicitly
    function automatic logic [IDX_W-1:0] f_wrap(input logic [IDX_W-1:0] base, input int unsigned k);
        int unsigned s;
        s = k + 32'(base);
        if (s >= PRF_WR_COUNT) s = s - PRF_WR_COUNT;
        return IDX_W'(s);
    endfunction

`ifndef PRF_WR_FIXED_PRIO_EN
    logic [PRF_BANK_COUNT-1:0][IDX_W-1:0]        r_rr_ptr;
`endif

    // Per-bank scan: first buffered requestor targeting the bank wins.
    // Depends only on buffer state, never on i_WR_valid, so ready has no comb loop.
    always_comb begin
        w_grant   = '0;
        w_win_vld = '0;
        w_win_idx = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int k = 0; k < PRF_WR_COUNT; k++) begin
`ifdef PRF_WR_FIXED_PRIO_EN
                if (!w_win_vld[b] && r_buf_valid[f_wrap('0, k)] &&
                    r_buf_pr[f_wrap('0, k)][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b)) begin
                    w_win_vld[b] = 1'b1;
                    w_win_idx[b] = f_wrap('0, k);
                end
`else
                if (!w_win_vld[b] && r_buf_valid[f_wrap(r_rr_ptr[b], k)] &&
                    r_buf_pr[f_wrap(r_rr_ptr[b], k)][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b)) begin
                    w_win_vld[b] = 1'b1;
                    w_win_idx[b] = f_wrap(r_rr_ptr[b], k);
                end
`endif
            end
            if (w_win_vld[b]) w_grant[w_win_idx[b]] = 1'b1;
        end
    end

    // A granted buffer drains this edge, so it may refill on the same edge
    assign w_ready = i_rst ? '0 : (~r_buf_valid | w_grant);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_valid  <= '0;
            r_bank_valid <= '0;
            r_bank_pr    <= '0;
            r_bank_data  <= '0;
        end else begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (i_WR_valid_by_wr[i] && w_ready[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_pr[i]    <= i_WR_PR_by_wr[i];
                    r_buf_data[i]  <= i_WR_data_by_wr[i];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                r_bank_valid[b] <= w_win_vld[b];
                // PR/data hold their last value on idle cycles
                if (w_win_vld[b]) begin
                    r_bank_pr[b]   <= r_buf_pr[w_win_idx[b]];
                    r_bank_data[b] <= r_buf_data[w_win_idx[b]];
                end
            end
        end
    end

`ifndef PRF_WR_FIXED_PRIO_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (w_win_vld[b]) r_rr_ptr[b] <= f_wrap(w_win_idx[b], 1);
            end
        end
    end
`endif

    assign o_WR_ready_by_wr        = w_ready;
    assign o_bank_WR_valid_by_bank = r_bank_valid;
    assign o_bank_WR_PR_by_bank    = r_bank_pr;
    assign o_bank_WR_data_by_bank  = r_bank_data;

endmodule
